// File: rtl/ritc_phase_scan_pkg.sv
// Shared types and default constants for the RITC phase-scan sequencer.
package ritc_phase_scan_pkg;

   localparam int unsigned DefStepW         = 10;
   localparam int unsigned DefSettleCycles  = 4;
   localparam int unsigned DefCaptureLat    = 3;
   localparam int unsigned DefTimeoutCycles = 1023;

   typedef enum logic [3:0] {
      StIdle,
      StScan,
      StCapture,
      StStep,
      StWaitDone,
      StSettle,
      StRetStep,
      StRetWait,
      StFinish
   } state_e;

   typedef struct packed {
      logic busy;
      logic done;
      logic aborted;
      logic timeout;
      logic edge_found;
   } status_t;

endpackage

// File: rtl/ritc_ps_step_handshake.sv
// One phase-shift step: PSEN pulse, wait for PSDONE, give up after TIMEOUT_CYCLES.
module ritc_ps_step_handshake
   import ritc_phase_scan_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic step_dir,
   input  logic psdone,
   output logic psen,
   output logic psincdec,
   output logic ack,
   output logic tmo
);

   localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

   logic            waiting_q;
   logic [TmrW-1:0] tmr_q;
   logic            dir_q;

   // The wait window opens the cycle after PSEN, so a same-cycle PSDONE is never taken.
   always_comb begin
      psen     = req;
      psincdec = req ? step_dir : dir_q;
      ack      = waiting_q & psdone;
      tmo      = waiting_q & ~psdone & (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waiting_q <= 1'b0;
         tmr_q     <= '0;
         dir_q     <= 1'b0;
      end else if (req) begin
         waiting_q <= 1'b1;
         tmr_q     <= '0;
         dir_q     <= step_dir;
      end else if (ack || tmo) begin
         waiting_q <= 1'b0;
      end else if (waiting_q) begin
         tmr_q <= tmr_q + TmrW'(1);
      end
   end

endmodule

// File: rtl/ritc_phase_scan_sequencer.sv
// Phase-scan sequencer: sweeps CLK_PS N steps, samples the scan bit at every point and reports
// the first 0->1 edge, the ones count and the running phase offset; optionally returns home.
module ritc_phase_scan_sequencer
   import ritc_phase_scan_pkg::*;
#(
   parameter int unsigned STEP_W         = DefStepW,
   parameter int unsigned SETTLE_CYCLES  = DefSettleCycles,
   parameter int unsigned CAPTURE_LAT    = DefCaptureLat,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic                     user_clk_i,
   input  logic                     user_rst_n_i,
   input  logic                     start_i,
   input  logic                     abort_i,
   input  logic [STEP_W-1:0]        nsteps_i,
   input  logic                     dir_i,
   input  logic                     return_i,
   output logic                     psen_o,
   output logic                     psincdec_o,
   input  logic                     psdone_i,
   output logic                     do_scan_o,
   input  logic                     scan_bit_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     aborted_o,
   output logic                     timeout_o,
   output logic                     edge_found_o,
   output logic [STEP_W-1:0]        edge_pos_o,
   output logic [STEP_W:0]          ones_count_o,
   output logic signed [STEP_W+1:0] pos_o
);

   localparam int unsigned CntMax = (SETTLE_CYCLES > CAPTURE_LAT) ? SETTLE_CYCLES : CAPTURE_LAT;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   state_e            state_q, state_d;
   logic [STEP_W-1:0] n_q, n_d, k_q, k_d, edge_pos_q, edge_pos_d;
   logic              dir_q, dir_d, ret_q, ret_d, prev_q, prev_d;
   logic              pend_q, pend_d, aborted_q, aborted_d, timeout_q, timeout_d;
   logic              edge_found_q, edge_found_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [STEP_W:0]   ones_q, ones_d;
   logic [STEP_W+1:0] pos_q, pos_d;
   logic              hs_req, hs_dir, hs_ack, hs_tmo;
   status_t           status;

   ritc_ps_step_handshake #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_step_handshake (
      .clk      (user_clk_i),
      .rst_n    (user_rst_n_i),
      .req      (hs_req),
      .step_dir (hs_dir),
      .psdone   (psdone_i),
      .psen     (psen_o),
      .psincdec (psincdec_o),
      .ack      (hs_ack),
      .tmo      (hs_tmo)
   );

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      k_d          = k_q;
      dir_d        = dir_q;
      ret_d        = ret_q;
      prev_d       = prev_q;
      pend_d       = pend_q;
      aborted_d    = aborted_q;
      timeout_d    = timeout_q;
      edge_found_d = edge_found_q;
      edge_pos_d   = edge_pos_q;
      cnt_d        = cnt_q;
      ones_d       = ones_q;
      pos_d        = pos_q;
      hs_req       = 1'b0;
      hs_dir       = dir_q;
      do_scan_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               n_d          = nsteps_i;
               dir_d        = dir_i;
               ret_d        = return_i;
               k_d          = '0;
               prev_d       = 1'b0;
               pend_d       = 1'b0;
               aborted_d    = 1'b0;
               timeout_d    = 1'b0;
               edge_found_d = 1'b0;
               edge_pos_d   = '0;
               ones_d       = '0;
               state_d      = StScan;
            end
         end
         StScan: begin
            do_scan_o = 1'b1;
            cnt_d     = '0;
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = StFinish;
            end else begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = StFinish;
            end else if (cnt_q == CntW'(CAPTURE_LAT - 1)) begin
               ones_d = ones_q + {{STEP_W{1'b0}}, scan_bit_i};
               if ((k_q != '0) && !prev_q && scan_bit_i && !edge_found_q) begin
                  edge_found_d = 1'b1;
                  edge_pos_d   = k_q;
               end
               prev_d = scan_bit_i;
               if (k_q == n_q) begin
                  state_d = (ret_q && (k_q != '0)) ? StRetStep : StFinish;
               end else begin
                  state_d = StStep;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StStep: begin
            hs_req  = 1'b1;
            hs_dir  = dir_q;
            pos_d   = dir_q ? pos_q + (STEP_W+2)'(1) : pos_q - (STEP_W+2)'(1);
            k_d     = k_q + STEP_W'(1);
            pend_d  = pend_q | abort_i;
            state_d = StWaitDone;
         end
         StWaitDone: begin
            // An abort here is deferred until the outstanding shift resolves.
            pend_d = pend_q | abort_i;
            if (hs_ack || hs_tmo) begin
               timeout_d = timeout_q | hs_tmo;
               aborted_d = aborted_q | pend_d;
               cnt_d     = '0;
               state_d   = (hs_tmo || pend_d) ? StFinish : StSettle;
            end
         end
         StSettle: begin
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = StFinish;
            end else if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
               state_d = StScan;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRetStep: begin
            hs_req  = 1'b1;
            hs_dir  = ~dir_q;
            pos_d   = dir_q ? pos_q - (STEP_W+2)'(1) : pos_q + (STEP_W+2)'(1);
            k_d     = k_q - STEP_W'(1);
            pend_d  = pend_q | abort_i;
            state_d = StRetWait;
         end
         StRetWait: begin
            pend_d = pend_q | abort_i;
            if (hs_ack || hs_tmo) begin
               timeout_d = timeout_q | hs_tmo;
               aborted_d = aborted_q | pend_d;
               state_d   = (hs_tmo || pend_d || (k_q == '0)) ? StFinish : StRetStep;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      status            = '0;
      status.busy       = (state_q != StIdle) && (state_q != StFinish);
      status.done       = (state_q == StFinish);
      status.aborted    = aborted_q;
      status.timeout    = timeout_q;
      status.edge_found = edge_found_q;
   end

   assign busy_o       = status.busy;
   assign done_o       = status.done;
   assign aborted_o    = status.aborted;
   assign timeout_o    = status.timeout;
   assign edge_found_o = status.edge_found;
   assign edge_pos_o   = edge_pos_q;
   assign ones_count_o = ones_q;
   assign pos_o        = pos_q;

   always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
      if (!user_rst_n_i) begin
         state_q      <= StIdle;
         n_q          <= '0;
         k_q          <= '0;
         dir_q        <= 1'b0;
         ret_q        <= 1'b0;
         prev_q       <= 1'b0;
         pend_q       <= 1'b0;
         aborted_q    <= 1'b0;
         timeout_q    <= 1'b0;
         edge_found_q <= 1'b0;
         edge_pos_q   <= '0;
         cnt_q        <= '0;
         ones_q       <= '0;
         pos_q        <= '0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         k_q          <= k_d;
         dir_q        <= dir_d;
         ret_q        <= ret_d;
         prev_q       <= prev_d;
         pend_q       <= pend_d;
         aborted_q    <= aborted_d;
         timeout_q    <= timeout_d;
         edge_found_q <= edge_found_d;
         edge_pos_q   <= edge_pos_d;
         cnt_q        <= cnt_d;
         ones_q       <= ones_d;
         pos_q        <= pos_d;
      end
   end

endmodule

// File: tb/tb_ritc_phase_scan_sequencer.sv
// Scoreboard bench for ritc_phase_scan_sequencer: directed and random sweeps checked on done_o.
module tb_ritc_phase_scan_sequencer;

   localparam int unsigned StepW  = 10;
   localparam int unsigned Settle = 4;
   localparam int unsigned Capt   = 3;
   localparam int unsigned TbTmo  = 60;

   typedef struct {
      int psen_fwd;
      int psen_ret;
      int scans;
      int edge_found;
      int edge_pos;
      int ones;
      int aborted;
      int timeout;
      int pos;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, start, abort, dir, ret, psdone, scan_bit;
   logic [StepW-1:0] nsteps;
   logic psen, psincdec, do_scan, busy, done, aborted, timeout, edge_found;
   logic [StepW-1:0] edge_pos;
   logic [StepW:0] ones;
   logic signed [StepW+1:0] pos;

   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   int model_pos = 0;
   int cyc = 0;
   int psen_fwd_cnt = 0, psen_ret_cnt = 0, scan_cnt = 0;
   int last_psen_cyc = 0, last_psdone_cyc = 0;
   bit outstanding = 1'b0;
   bit cur_dir = 1'b0;
   logic [63:0] cfg_bits = '0;
   int cfg_tmo_step = 0, cfg_abort_step = 0;
   int step_no = 0, scan_no = 0;
   logic sb_v;

   ritc_phase_scan_sequencer #(
      .STEP_W         (StepW),
      .SETTLE_CYCLES  (Settle),
      .CAPTURE_LAT    (Capt),
      .TIMEOUT_CYCLES (TbTmo)
   ) dut (
      .user_clk_i   (clk),
      .user_rst_n_i (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .nsteps_i     (nsteps),
      .dir_i        (dir),
      .return_i     (ret),
      .psen_o       (psen),
      .psincdec_o   (psincdec),
      .psdone_i     (psdone),
      .do_scan_o    (do_scan),
      .scan_bit_i   (scan_bit),
      .busy_o       (busy),
      .done_o       (done),
      .aborted_o    (aborted),
      .timeout_o    (timeout),
      .edge_found_o (edge_found),
      .edge_pos_o   (edge_pos),
      .ones_count_o (ones),
      .pos_o        (pos)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: what one run should produce, from the sweep rules alone.
   function automatic exp_t model(input int n, input bit d, input bit r, input logic [63:0] bits,
                                  input int tmo_s, input int ab_s, input int pos0);
      exp_t e;
      int steps, samples;
      logic signed [StepW+1:0] p;
      e = '{default: 0};
      if (tmo_s != 0) begin
         steps = tmo_s; samples = tmo_s; e.timeout = 1;
      end else if (ab_s != 0) begin
         steps = ab_s; samples = ab_s; e.aborted = 1;
      end else begin
         steps = n; samples = n + 1;
      end
      e.psen_fwd = steps;
      e.psen_ret = (e.timeout == 0 && e.aborted == 0 && r) ? n : 0;
      e.scans    = samples;
      for (int i = 0; i < samples; i++) begin
         e.ones += int'(bits[i]);
         if (i > 0 && e.edge_found == 0 && !bits[i-1] && bits[i]) begin
            e.edge_found = 1;
            e.edge_pos   = i;
         end
      end
      p = (StepW+2)'(pos0 + (d ? 1 : -1) * (steps - e.psen_ret));
      e.pos = int'(p);
      return e;
   endfunction

   // PSDONE responder: withholds or delays per run configuration, injects the abort.
   always begin
      @(negedge clk);
      if (psen) begin
         step_no++;
         if (step_no == cfg_tmo_step) begin
         end else if (step_no == cfg_abort_step) begin
            @(posedge clk); #1 abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
            repeat (19) @(posedge clk);
            #1 psdone = 1'b1;
            @(posedge clk); #1 psdone = 1'b0;
         end else begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1 psdone = 1'b1;
            @(posedge clk); #1 psdone = 1'b0;
         end
      end
   end

   // Scan pipeline: wrong value until CAPTURE_LAT cycles after do_scan, then the true sample.
   always begin
      @(negedge clk);
      if (do_scan) begin
         sb_v = cfg_bits[scan_no];
         scan_no++;
         scan_bit = ~sb_v;
         repeat (Capt) @(posedge clk);
         #1 scan_bit = sb_v;
      end
   end

   // Monitor: counts pulses and checks the scoreboard entry on every done_o.
   always @(negedge clk) begin
      exp_t e;
      if (psen) begin
         chk("psen_while_outstanding", int'(outstanding), 0);
         outstanding   = 1'b1;
         last_psen_cyc = cyc;
         if (psincdec == cur_dir) psen_fwd_cnt++;
         else psen_ret_cnt++;
      end else if (psdone && outstanding) begin
         outstanding     = 1'b0;
         last_psdone_cyc = cyc;
      end
      if (do_scan) scan_cnt++;
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("psen_fwd", psen_fwd_cnt, e.psen_fwd);
            chk("psen_ret", psen_ret_cnt, e.psen_ret);
            chk("scans", scan_cnt, e.scans);
            chk("edge_found", int'(edge_found), e.edge_found);
            chk("edge_pos", int'(edge_pos), e.edge_pos);
            chk("ones", int'(ones), e.ones);
            chk("aborted", int'(aborted), e.aborted);
            chk("timeout", int'(timeout), e.timeout);
            chk("pos", int'(pos), e.pos);
            chk("busy_at_done", int'(busy), 0);
            if (e.timeout != 0)
               chk("timeout_latency_ok", int'((cyc - last_psen_cyc >= int'(TbTmo)) &&
                                              (cyc - last_psen_cyc <= int'(TbTmo) + 2)), 1);
            if (e.aborted != 0) chk("abort_done_latency", cyc - last_psdone_cyc, 1);
         end
         psen_fwd_cnt = 0;
         psen_ret_cnt = 0;
         scan_cnt     = 0;
         outstanding  = 1'b0;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_flags"}, int'({busy, done, aborted, timeout, edge_found, psen, psincdec,
                                do_scan}), 0);
      chk({tag, "_edge_pos"}, int'(edge_pos), 0);
      chk({tag, "_ones"}, int'(ones), 0);
      chk({tag, "_pos"}, int'(pos), 0);
   endtask

   task automatic run(input int n, input bit d, input bit r, input logic [63:0] bits,
                      input int tmo_s, input int ab_s, input bit extra_start);
      exp_t e;
      bit got;
      e = model(n, d, r, bits, tmo_s, ab_s, model_pos);
      model_pos = e.pos;
      sb.push_back(e);
      cfg_bits = bits; cfg_tmo_step = tmo_s; cfg_abort_step = ab_s;
      step_no = 0; scan_no = 0; cur_dir = d;
      @(negedge clk);
      nsteps = StepW'(n); dir = d; ret = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      if (extra_start) begin
         repeat (3) @(negedge clk);
         nsteps = StepW'(n + 3); dir = ~d; ret = ~r; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (got) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("start_on_done_ignored", int'(busy), 0);
      end else begin
         chk("done_within_bound", 0, 1);
         sb.delete();
      end
   endtask

   task automatic reset_mid_settle();
      bit got;
      cfg_bits = 64'hFF; cfg_tmo_step = 0; cfg_abort_step = 0;
      step_no = 0; scan_no = 0; cur_dir = 1'b1;
      @(negedge clk);
      nsteps = 4; dir = 1'b1; ret = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (psdone) begin
            got = 1'b1;
            break;
         end
      end
      chk("psdone_before_reset", int'(got), 1);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("mid_settle_reset");
      model_pos = 0; psen_fwd_cnt = 0; psen_ret_cnt = 0; scan_cnt = 0; outstanding = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; psdone = 1'b0; scan_bit = 1'b0;
      dir = 1'b0; ret = 1'b0; nsteps = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("initial_reset");
      rst_n = 1'b1;
      run(8, 1'b1, 1'b1, 64'h1F0, 0, 0, 1'b0);
      run(8, 1'b1, 1'b0, 64'h1F0, 0, 0, 1'b0);
      run(8, 1'b1, 1'b0, 64'h1F0, 3, 0, 1'b0);
      run(8, 1'b1, 1'b1, 64'h1F0, 0, 2, 1'b0);
      run(0, 1'b0, 1'b1, 64'h1, 0, 0, 1'b0);
      run(2, 1'b0, 1'b0, 64'h5, 0, 0, 1'b1);
      reset_mid_settle();
      run(5, 1'b0, 1'b1, 64'h3C, 0, 0, 1'b0);
      for (int r = 0; r < 10; r++) begin
         run(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, 0, 0, 1'b0);
      end
      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
